// File: rtl/uart_fifo_link.sv
// rtl/uart_fifo_link.sv - UART transceiver with TX/RX FIFOs, sticky errors, echo and loopback modes
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   rx, tx             serial input (asynchronous, idle high) / serial output (idle high)
//   mode               00 normal, 01 echo, 10 internal loopback, 11 same as 00
//   tx_data, tx_wr     byte and write strobe into the TX FIFO; tx_full flags a full TX FIFO
//   rx_data, rx_rd     show-ahead head of the RX FIFO and its pop strobe
//   rx_empty, rx_count RX FIFO empty flag and occupancy
//   frame_err, overrun sticky receive errors, cleared by clr_err (a new error wins)
module uart_fifo_link #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          tx,
    input  logic [1:0]                    mode,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_rd,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]    M_NORMAL  = 2'd0;
    localparam logic [1:0]    M_ECHO    = 2'd1;
    localparam logic [1:0]    M_LOOP    = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [1:0] mode_n;
    assign mode_n = (mode == 2'b11) ? M_NORMAL : mode;

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp, tx_rp;
    logic [AW:0]          tx_cnt;
    logic                 tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_push_data;

    // TX FSM / datapath
    state_t               tx_state, tx_next;
    logic [CW-1:0]        tx_bit_cnt;
    logic [IW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_line, tx_line_d, tx_tick;
    logic [1:0]           tx_mode;

    // RX FIFO
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wp, rx_rp;
    logic                 rx_full, rx_push, rx_pop;

    // RX FSM / datapath
    state_t               rx_state, rx_next;
    logic [CW-1:0]        rx_bit_cnt;
    logic [IW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_meta, rx_sync, rx_in, rx_tick, rx_half;
    logic                 rx_done, frame_set, ovr_set, echo_push;
    logic [1:0]           rx_mode;

    // ---------------- TX FIFO ----------------
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == DEPTH);
    // Echo traffic owns the TX FIFO write port; tx_wr is ignored in echo mode.
    assign echo_push    = rx_push && (rx_mode == M_ECHO);
    assign tx_push_data = echo_push ? rx_shift : tx_data;
    assign tx_push      = (echo_push || (tx_wr && mode_n != M_ECHO)) && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= tx_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (AW + 1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    assign tx_tick = (tx_bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (!tx_empty) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_idx == IDX_LAST) tx_next = S_STOP;
            S_STOP:  if (tx_tick) tx_next = tx_empty ? S_IDLE : S_START;
            default: tx_next = S_IDLE;
        endcase
    end

    // The line level is registered, so tx follows the state by one cycle.
    always_comb begin
        tx_pop    = 1'b0;
        tx_line_d = 1'b1;
        case (tx_state)
            S_IDLE:  tx_pop = !tx_empty;
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_shift[0];
            S_STOP:  tx_pop = tx_tick && !tx_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_line    <= 1'b1;
            tx_bit_cnt <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx_mode    <= M_NORMAL;
        end else begin
            tx_line <= tx_line_d;
            if (tx_state == S_IDLE) tx_mode <= mode_n;
            if (tx_pop) begin
                tx_shift   <= tx_mem[tx_rp];
                tx_bit_cnt <= '0;
                tx_idx     <= '0;
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_bit_cnt <= '0;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + IW'(1);
                    end
                end else begin
                    tx_bit_cnt <= tx_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign tx = (tx_mode == M_LOOP) ? 1'b1 : tx_line;

    // ---------------- RX input ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // The internal TX line is already synchronous, so loopback bypasses the synchroniser.
    assign rx_in = (rx_mode == M_LOOP) ? tx_line : rx_sync;

    // ---------------- RX FSM ----------------
    assign rx_tick = (rx_bit_cnt == BIT_LAST);
    assign rx_half = (rx_bit_cnt == HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rx_in) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_in ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_idx == IDX_LAST) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    // A pop on the same edge frees a slot, so a full FIFO only overruns without rx_rd.
    always_comb begin
        rx_done   = (rx_state == S_STOP) && rx_tick;
        rx_push   = rx_done && rx_in && (!rx_full || rx_rd);
        frame_set = rx_done && !rx_in;
        ovr_set   = rx_done && rx_in && rx_full && !rx_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_bit_cnt <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_mode    <= M_NORMAL;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_mode    <= mode_n;
                    rx_bit_cnt <= '0;
                    rx_idx     <= '0;
                end
                S_START: rx_bit_cnt <= rx_half ? '0 : rx_bit_cnt + CW'(1);
                S_DATA: begin
                    if (rx_tick) begin
                        rx_bit_cnt <= '0;
                        rx_shift   <= {rx_in, rx_shift[DATA_BITS-1:1]};
                        rx_idx     <= rx_idx + IW'(1);
                    end else begin
                        rx_bit_cnt <= rx_bit_cnt + CW'(1);
                    end
                end
                S_STOP:  rx_bit_cnt <= rx_tick ? '0 : rx_bit_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == DEPTH);
    assign rx_pop   = rx_rd && (!rx_empty || rx_push);
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (AW + 1)'(1);
                2'b01:   rx_count <= rx_count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- Sticky errors ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_link.sv
// tb/tb_uart_fifo_link.sv - randomized self-checking bench for uart_fifo_link
module tb_uart_fifo_link;
    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       tx;
    logic [1:0] mode = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_rd = 1'b0;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       frame_err, overrun;
    logic       clr_err = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected RX FIFO contents and expected sticky flags.
    logic [7:0] rx_model[$];
    logic       exp_fe = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_fifo_link #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .mode(mode),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
        .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_count(rx_count),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one serial frame on rx; report the cycle rx_empty fell and the cycle tx first went low.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit,
                           output int empty_fall, output int tx_low);
        logic [9:0] fr;
        logic       prev_empty;
        int         n;
        fr = {stop_bit, b, 1'b0};
        empty_fall = -1;
        tx_low = -1;
        prev_empty = rx_empty;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            for (int j = 0; j < CPB; j++) begin
                step(1);
                n++;
                if (empty_fall < 0 && prev_empty && !rx_empty) empty_fall = n;
                prev_empty = rx_empty;
                if (tx_low < 0 && tx === 1'b0) tx_low = n;
            end
        end
        rx = 1'b1;
    endtask

    // Model the receiver's outcome for a frame from the stop bit and FIFO occupancy.
    task automatic model_rx(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) exp_fe = 1'b1;
        else if (rx_model.size() < DEPTH) rx_model.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    // Entered pos cycles after the start bit began; samples every bit at its middle and
    // returns at the first cycle after the stop bit.
    task automatic check_tx_frame(input logic [7:0] b, input int pos, input string tag);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        step(CPB / 2 - pos);
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("%s_bit%0d", tag, k), tx, fr[k]);
            if (k < 9) step(CPB);
        end
        step(CPB / 2);
    endtask

    task automatic wait_tx_fall(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (tx === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic drain_rx(input string tag);
        while (rx_model.size() > 0) begin
            check_eq($sformatf("%s_data", tag), rx_data, rx_model[0]);
            rx_rd = 1'b1;
            step(1);
            rx_rd = 1'b0;
            void'(rx_model.pop_front());
        end
        check_eq($sformatf("%s_empty", tag), rx_empty, 1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        exp_fe = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        int         ef, tf, n, t1, t2;
        logic       seen, pin_bad;
        logic [7:0] b;
        logic [7:0] w[6];
        logic [2:0] last;

        // Reset state
        step(3);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_tx_full", tx_full, 0);
        check_eq("rst_rx_empty", rx_empty, 1);
        check_eq("rst_rx_count", rx_count, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        reset = 1'b0;
        step(2);

        // Single TX byte: start bit appears two edges after the write
        tx_data = 8'h41;
        tx_wr = 1'b1;
        step(1);
        tx_wr = 1'b0;
        check_eq("tx_lat_e0", tx, 1);
        step(1);
        check_eq("tx_lat_e1", tx, 1);
        step(1);
        check_eq("tx_lat_e2", tx, 0);
        check_tx_frame(8'h41, 0, "t41");
        check_eq("t41_idle", tx, 1);
        step(20);

        // Single RX byte
        send_rx(8'hA5, 1'b1, ef, tf);
        model_rx(8'hA5, 1'b1);
        check_eq("rxA5_latency_window", (ef >= 146 && ef <= 160), 1);
        check_eq("rxA5_count", rx_count, rx_model.size());
        drain_rx("rxA5");

        // Overrun: one more frame than the FIFO holds, no reads
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i), 1'b1, ef, tf);
            model_rx(8'(i), 1'b1);
        end
        check_eq("ovr_count", rx_count, rx_model.size());
        check_eq("ovr_head", rx_data, rx_model[0]);
        check_eq("ovr_flag", overrun, exp_ovr);
        check_eq("ovr_fe", frame_err, exp_fe);
        pulse_clr();
        check_eq("ovr_cleared", overrun, 0);
        drain_rx("ovr");

        // Random RX bursts within FIFO capacity
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_rx(b, 1'b1, ef, tf);
                model_rx(b, 1'b1);
                check_eq($sformatf("rnd%0d_count", r), rx_count, rx_model.size());
            end
            drain_rx($sformatf("rnd%0d", r));
        end

        // Framing error leaves FIFO untouched; a short glitch is ignored
        b = 8'($urandom);
        send_rx(b, 1'b1, ef, tf);
        model_rx(b, 1'b1);
        send_rx(8'h3C, 1'b0, ef, tf);
        model_rx(8'h3C, 1'b0);
        step(40);
        check_eq("fe_flag", frame_err, exp_fe);
        check_eq("fe_count", rx_count, rx_model.size());
        check_eq("fe_ovr", overrun, exp_ovr);
        pulse_clr();
        check_eq("fe_cleared", frame_err, 0);
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        check_eq("glitch_count", rx_count, rx_model.size());
        check_eq("glitch_fe", frame_err, 0);
        check_eq("glitch_ovr", overrun, 0);
        drain_rx("fe");

        // TX FIFO fill: five rapid writes fill it (first byte leaves on edge 1), sixth is dropped
        check_eq("txf_pre_full", tx_full, 0);
        for (int i = 0; i < 6; i++) begin
            w[i] = 8'($urandom);
            tx_data = w[i];
            tx_wr = 1'b1;
            step(1);
            if (i == 4) check_eq("txf_full", tx_full, 1);
        end
        tx_wr = 1'b0;
        check_eq("txf_still_full", tx_full, 1);
        check_tx_frame(w[0], 3, "txf0");
        for (int i = 1; i < 5; i++) begin
            check_eq($sformatf("txf%0d_b2b", i), tx, 0);
            check_tx_frame(w[i], 0, $sformatf("txf%0d", i));
        end
        wait_tx_fall(40, seen);
        check_eq("txf_sixth_dropped", seen, 0);

        // Loopback: pin stays high, rx pin ignored, frames arrive one frame-time apart
        mode = 2'b10;
        step(3);
        rx = 1'b0;
        tx_data = 8'h5A;
        tx_wr = 1'b1;
        step(1);
        tx_data = 8'hC3;
        step(1);
        tx_wr = 1'b0;
        pin_bad = 1'b0;
        t1 = -1;
        t2 = -1;
        last = rx_count;
        for (int i = 1; i <= 400; i++) begin
            step(1);
            if (tx !== 1'b1) pin_bad = 1'b1;
            if (rx_count != last) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
                last = rx_count;
            end
        end
        model_rx(8'h5A, 1'b1);
        model_rx(8'hC3, 1'b1);
        check_eq("lb_pin_high", pin_bad, 0);
        check_eq("lb_count", rx_count, rx_model.size());
        check_eq("lb_gap", t2 - t1, 10 * CPB);
        rx = 1'b1;
        step(5);
        drain_rx("lb");
        mode = 2'b00;
        step(5);

        // Echo: received byte is retransmitted, tx_wr ignored
        mode = 2'b01;
        step(3);
        tx_data = 8'h11;
        tx_wr = 1'b1;
        step(1);
        tx_wr = 1'b0;
        send_rx(8'h7E, 1'b1, ef, tf);
        model_rx(8'h7E, 1'b1);
        check_eq("echo_tx_start", (tf > 0 && 10 * CPB - tf <= CPB / 2), 1);
        if (tf > 0 && 10 * CPB - tf <= CPB / 2) check_tx_frame(8'h7E, 10 * CPB - tf, "echo");
        wait_tx_fall(40, seen);
        check_eq("echo_no_extra", seen, 0);
        check_eq("echo_rx_count", rx_count, rx_model.size());
        check_eq("echo_rx_data", rx_data, rx_model[0]);

        // Reset in the middle of an echoed frame
        send_rx(8'h30, 1'b1, ef, tf);
        model_rx(8'h30, 1'b1);
        step(20);
        check_eq("echo_inflight_low", tx, 0);
        reset = 1'b1;
        step(1);
        rx_model.delete();
        check_eq("mid_rst_tx", tx, 1);
        check_eq("mid_rst_rx_empty", rx_empty, 1);
        check_eq("mid_rst_rx_count", rx_count, 0);
        check_eq("mid_rst_rx_data", rx_data, 0);
        check_eq("mid_rst_tx_full", tx_full, 0);
        reset = 1'b0;
        wait_tx_fall(200, seen);
        check_eq("mid_rst_tx_quiet", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
